// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for pipeline-stage registers
// Purpose: stage state encoding, per-stage vector widths, ctrl bit positions,
// default bubble kill masks, and an occupancy helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    localparam int CTRL_W_DEFAULT = 16;

    // Per-stage data widths (32-bit fields)
    localparam int IFID_DATA_W  = 64;   // NPC, instr
    localparam int IDEX_DATA_W  = 192;  // NPC, rdat1, rdat2, instr, imm, spare
    localparam int EXMEM_DATA_W = 160;  // NPC, aluout, rdat2, instr, imm
    localparam int MEMWB_DATA_W = 128;  // NPC, aluout, dmemload, instr

    // Ctrl bit positions
    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_DREN      = 1;
    localparam int CTRL_DWEN      = 2;
    localparam int CTRL_HALT      = 3;
    localparam int CTRL_ALUOP_LSB = 4;   // 4 bits: [7:4]
    localparam int CTRL_ALUSRC    = 8;
    localparam int CTRL_MEMTOREG  = 9;
    localparam int CTRL_REGDST    = 10;
    localparam int CTRL_PCSEL_LSB = 11;  // 2 bits: [12:11]

    // Bits that must never act from a bubble: regwrite, dmemREN, dmemWEN, halt
    localparam logic [15:0] KILL_MASK_IFID  = 16'h000F;
    localparam logic [15:0] KILL_MASK_IDEX  = 16'h000F;
    localparam logic [15:0] KILL_MASK_EXMEM = 16'h000F;
    localparam logic [15:0] KILL_MASK_MEMWB = 16'h000F;

    function automatic logic [1:0] occupancy_of(input stage_state_t s);
        case (s)
            ONE:     occupancy_of = 2'd1;
            FULL:    occupancy_of = 2'd2;
            default: occupancy_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one ctrl+data storage entry with load enable
// Purpose: holds one stage entry; async clear to zero, loads on load=1.
// Ports: CLK, nRST (async active-low), load, d_ctrl/d_data in, q_ctrl/q_data out.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 192
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              load,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (load) begin
            ctrl_d = d_ctrl;
            data_d = d_data;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign q_ctrl = ctrl_q;
    assign q_data = data_q;

endmodule

// File: rtl/pipe_stage_latch.sv
// rtl/pipe_stage_latch.sv - parametrised valid/ready pipeline-stage register
// Purpose: carries ctrl/data vectors between pipeline stages, with optional
// 2-entry skid buffer, synchronous flush, hold, and bubble ctrl masking.
// Ports: CLK, nRST (async active-low); in_valid/in_ready/in_ctrl/in_data
// upstream; hold, flush; out_valid/out_ready/out_ctrl/out_data downstream;
// occupancy (0..2).
module pipe_stage_latch
    import pipe_pkg::*;
#(
    parameter int                CTRL_W    = 16,
    parameter int                DATA_W    = 192,
    parameter logic [CTRL_W-1:0] KILL_MASK = 16'h000F,
    parameter bit                SKID      = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hold,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    stage_state_t state_q, state_d;

    logic              in_fire, out_fire;
    logic              main_load, skid_load, main_from_skid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
    logic [DATA_W-1:0] main_data, skid_data, main_d_data;

    // With SKID=0 the ONE->FULL arc is unreachable: in ONE an in_fire needs
    // out_ready, which makes it a simultaneous out_fire.
    assign in_ready = !hold && !flush &&
                      (SKID ? (state_q != FULL) : (state_q == EMPTY || out_ready));
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d        = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_d_data = main_from_skid ? skid_data : in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .CLK    (CLK),
        .nRST   (nRST),
        .load   (main_load),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .q_ctrl (main_ctrl),
        .q_data (main_data)
    );

    if (SKID) begin : g_skid
        pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .CLK    (CLK),
            .nRST   (nRST),
            .load   (skid_load),
            .d_ctrl (in_ctrl),
            .d_data (in_data),
            .q_ctrl (skid_ctrl),
            .q_data (skid_data)
        );
    end else begin : g_noskid
        assign skid_ctrl = '0;
        assign skid_data = '0;
    end

    // Hazardous ctrl bits go low whenever the head is a bubble; data stays stale.
    assign out_ctrl  = main_ctrl & ~(out_valid ? {CTRL_W{1'b0}} : KILL_MASK);
    assign out_data  = main_data;
    assign occupancy = occupancy_of(state_q);

endmodule

// File: tb/tb_pipe_stage_latch.sv
// tb/tb_pipe_stage_latch.sv - testbench for pipe_stage_latch (SKID=1 and SKID=0)
module tb_pipe_stage_latch;

    localparam logic [15:0] KM = 16'h000F;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         in_valid, hold, flush, out_ready;
    logic [15:0]  in_ctrl;
    logic [191:0] in_data;

    logic         s1_in_ready, s1_out_valid, s0_in_ready, s0_out_valid;
    logic [15:0]  s1_out_ctrl, s0_out_ctrl;
    logic [191:0] s1_out_data, s0_out_data;
    logic [1:0]   s1_occ, s0_occ;

    always #5 CLK = ~CLK;

    pipe_stage_latch #(.SKID(1'b1)) dut (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(s1_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .hold(hold), .flush(flush),
        .out_valid(s1_out_valid), .out_ready(out_ready), .out_ctrl(s1_out_ctrl),
        .out_data(s1_out_data), .occupancy(s1_occ)
    );

    pipe_stage_latch #(.SKID(1'b0)) dut0 (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(s0_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .hold(hold), .flush(flush),
        .out_valid(s0_out_valid), .out_ready(out_ready), .out_ctrl(s0_out_ctrl),
        .out_data(s0_out_data), .occupancy(s0_occ)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iv, hd, fl, ordy;
        logic [15:0] ictrl;
        logic [31:0] idata;
        logic        e_ir, e_ov;
        logic [1:0]  e_occ;
        logic [15:0] e_ctrl;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mk(input logic iv, hd, fl, ordy, input logic [15:0] ictrl,
                                input logic [31:0] idata, input logic e_ir, e_ov,
                                input logic [1:0] e_occ, input logic [15:0] e_ctrl,
                                input logic [31:0] e_data);
        vec_t v;
        v.iv = iv; v.hd = hd; v.fl = fl; v.ordy = ordy; v.ictrl = ictrl; v.idata = idata;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_occ = e_occ; v.e_ctrl = e_ctrl; v.e_data = e_data;
        return v;
    endfunction

    typedef struct {
        logic [15:0]  c;
        logic [191:0] d;
    } entry_t;

    entry_t mq0[$];
    entry_t mq1[$];

    task automatic set_in(input logic iv, hd, fl, ordy, input logic [15:0] c, input logic [31:0] d);
        in_valid = iv; hold = hd; flush = fl; out_ready = ordy;
        in_ctrl = c; in_data = {160'b0, d};
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        set_in(0, 0, 0, 0, 16'h0, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    vec_t vt[18];

    initial begin
        nRST = 1'b0;
        set_in(0, 0, 0, 0, 16'h0, 32'h0);

        //          iv hd fl or ctrl      data   | ir ov occ ctrl      data
        vt[0]  = mk(1, 0, 0, 1, 16'h00F1, 32'h1,  1, 0, 0, 16'h0000, 32'h0);
        vt[1]  = mk(1, 0, 0, 1, 16'h00F1, 32'h2,  1, 1, 1, 16'h00F1, 32'h1);
        vt[2]  = mk(1, 0, 0, 1, 16'h00F1, 32'h3,  1, 1, 1, 16'h00F1, 32'h2);
        vt[3]  = mk(1, 0, 0, 1, 16'h00F1, 32'h4,  1, 1, 1, 16'h00F1, 32'h3);
        vt[4]  = mk(0, 0, 0, 1, 16'h0000, 32'h0,  1, 1, 1, 16'h00F1, 32'h4);
        vt[5]  = mk(1, 0, 0, 0, 16'h0011, 32'hA,  1, 0, 0, 16'h00F0, 32'h4);
        vt[6]  = mk(1, 0, 0, 0, 16'h0022, 32'hB,  1, 1, 1, 16'h0011, 32'hA);
        vt[7]  = mk(1, 0, 0, 0, 16'h0033, 32'hC,  0, 1, 2, 16'h0011, 32'hA);
        vt[8]  = mk(1, 0, 0, 1, 16'h0033, 32'hC,  0, 1, 2, 16'h0011, 32'hA);
        vt[9]  = mk(1, 0, 0, 1, 16'h0033, 32'hC,  1, 1, 1, 16'h0022, 32'hB);
        vt[10] = mk(0, 0, 0, 1, 16'h0000, 32'h0,  1, 1, 1, 16'h0033, 32'hC);
        vt[11] = mk(1, 0, 0, 0, 16'h00FF, 32'h5,  1, 0, 0, 16'h0030, 32'hC);
        vt[12] = mk(1, 0, 1, 0, 16'h00FF, 32'h6,  0, 1, 1, 16'h00FF, 32'h5);
        vt[13] = mk(0, 0, 0, 0, 16'h0000, 32'h0,  1, 0, 0, 16'h00F0, 32'h5);
        vt[14] = mk(1, 0, 0, 0, 16'h0012, 32'h7,  1, 0, 0, 16'h00F0, 32'h5);
        vt[15] = mk(1, 1, 0, 1, 16'h0012, 32'h8,  0, 1, 1, 16'h0012, 32'h7);
        vt[16] = mk(1, 1, 0, 1, 16'h0012, 32'h8,  0, 0, 0, 16'h0010, 32'h7);
        vt[17] = mk(1, 1, 0, 1, 16'h0012, 32'h8,  0, 0, 0, 16'h0010, 32'h7);

        // reset state
        #2;
        chk("rst_out_valid", {191'b0, s1_out_valid}, 192'd0);
        chk("rst_occupancy", {190'b0, s1_occ}, 192'd0);
        chk("rst_out_ctrl", {176'b0, s1_out_ctrl}, 192'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // streaming, skid fill/drain, flush, hold
        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge CLK);
            set_in(vt[i].iv, vt[i].hd, vt[i].fl, vt[i].ordy, vt[i].ictrl, vt[i].idata);
            #1;
            chk($sformatf("vec%0d_in_ready", i), {191'b0, s1_in_ready}, {191'b0, vt[i].e_ir});
            chk($sformatf("vec%0d_out_valid", i), {191'b0, s1_out_valid}, {191'b0, vt[i].e_ov});
            chk($sformatf("vec%0d_occupancy", i), {190'b0, s1_occ}, {190'b0, vt[i].e_occ});
            chk($sformatf("vec%0d_out_ctrl", i), {176'b0, s1_out_ctrl}, {176'b0, vt[i].e_ctrl});
            chk($sformatf("vec%0d_out_data", i), s1_out_data, {160'b0, vt[i].e_data});
        end

        // async reset while FULL, checked before any clock edge
        @(negedge CLK);
        set_in(1, 0, 0, 0, 16'h00FF, 32'h9);
        @(negedge CLK);
        set_in(1, 0, 0, 0, 16'h00FF, 32'h10);
        @(negedge CLK);
        set_in(0, 0, 0, 0, 16'h0, 32'h0);
        #1;
        chk("full_before_rst_occ", {190'b0, s1_occ}, 192'd2);
        #2;
        nRST = 1'b0;
        #1;
        chk("async_rst_out_valid", {191'b0, s1_out_valid}, 192'd0);
        chk("async_rst_occ", {190'b0, s1_occ}, 192'd0);
        chk("async_rst_out_ctrl", {176'b0, s1_out_ctrl}, 192'd0);
        chk("async_rst_out_data", s1_out_data, 192'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // SKID=0: combinational ready and one-cycle swap
        @(negedge CLK);
        set_in(1, 0, 0, 0, 16'h0061, 32'h61);
        #1;
        chk("s0_empty_in_ready", {191'b0, s0_in_ready}, 192'd1);
        @(negedge CLK);
        set_in(1, 0, 0, 0, 16'h0062, 32'h62);
        #1;
        chk("s0_stall_in_ready", {191'b0, s0_in_ready}, 192'd0);
        chk("s0_stall_occ", {190'b0, s0_occ}, 192'd1);
        chk("s0_stall_data", s0_out_data, 192'h61);
        out_ready = 1'b1;
        #1;
        chk("s0_comb_in_ready", {191'b0, s0_in_ready}, 192'd1);
        @(negedge CLK);
        set_in(0, 0, 0, 0, 16'h0, 32'h0);
        #1;
        chk("s0_swap_out_valid", {191'b0, s0_out_valid}, 192'd1);
        chk("s0_swap_occ", {190'b0, s0_occ}, 192'd1);
        chk("s0_swap_data", s0_out_data, 192'h62);
        chk("s0_swap_ctrl", {176'b0, s0_out_ctrl}, 192'h62);

        // randomized run against a queue model for both configurations
        do_reset();
        mq0.delete();
        mq1.delete();
        for (int n = 0; n < 600; n++) begin
            logic m_ir0, m_ir1, iv;
            @(negedge CLK);
            iv = ($urandom_range(0, 9) < 7);
            set_in(iv, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                   ($urandom_range(0, 9) < 6), 16'($urandom_range(0, 65535)), $urandom);
            #1;
            m_ir1 = !hold && !flush && (mq1.size() < 2);
            m_ir0 = !hold && !flush && (mq0.size() == 0 || out_ready);

            chk("rnd1_in_ready", {191'b0, s1_in_ready}, {191'b0, m_ir1});
            chk("rnd1_out_valid", {191'b0, s1_out_valid}, {191'b0, (mq1.size() > 0)});
            chk("rnd1_occ", {190'b0, s1_occ}, 192'(mq1.size()));
            if (mq1.size() > 0) begin
                chk("rnd1_ctrl", {176'b0, s1_out_ctrl}, {176'b0, mq1[0].c});
                chk("rnd1_data", s1_out_data, mq1[0].d);
            end else begin
                chk("rnd1_bubble_ctrl", {176'b0, s1_out_ctrl & KM}, 192'd0);
            end

            chk("rnd0_in_ready", {191'b0, s0_in_ready}, {191'b0, m_ir0});
            chk("rnd0_out_valid", {191'b0, s0_out_valid}, {191'b0, (mq0.size() > 0)});
            chk("rnd0_occ", {190'b0, s0_occ}, 192'(mq0.size()));
            if (mq0.size() > 0) begin
                chk("rnd0_ctrl", {176'b0, s0_out_ctrl}, {176'b0, mq0[0].c});
                chk("rnd0_data", s0_out_data, mq0[0].d);
            end else begin
                chk("rnd0_bubble_ctrl", {176'b0, s0_out_ctrl & KM}, 192'd0);
            end

            // model update for the coming edge
            if (flush) begin
                mq1.delete();
                mq0.delete();
            end else begin
                entry_t e;
                e.c = in_ctrl;
                e.d = in_data;
                if (mq1.size() > 0 && out_ready) void'(mq1.pop_front());
                if (in_valid && m_ir1) mq1.push_back(e);
                if (mq0.size() > 0 && out_ready) void'(mq0.pop_front());
                if (in_valid && m_ir0) mq0.push_back(e);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
